pcie_cc_cpl_framer: RTL and testbench

//  Builds PCIe Completer Completion (CC) frames on a single-region MFB bus. Sits directly upstream
//  of the CC MFB->AXI converter, feeding its MFB CC input. Per accepted completion request it emits
//  a 3-DW CC descriptor followed by the payload. Payload is realigned by 3 DWs across MFB words.

---
 rtl/pcie_cc_cpl_framer.sv | 166 ++++++++++++++++
 tb/tb_pcie_cc_cpl_framer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_cc_cpl_framer.sv
// PCIe Completer Completion framer: a 3-DW CC descriptor followed by the payload,
// realigned by 3 DWs, on a single-region MFB bus with a registered output stage.
module pcie_cc_cpl_framer #(
   parameter int MFB_REGIONS     = 1,
   parameter int MFB_REGION_SIZE = 1,
   parameter int MFB_BLOCK_SIZE  = 8,
   parameter int MFB_ITEM_WIDTH  = 32,
   localparam int ITEMS  = MFB_REGIONS * MFB_REGION_SIZE * MFB_BLOCK_SIZE,
   localparam int DATA_W = ITEMS * MFB_ITEM_WIDTH,
   localparam int POS_W  = $clog2(ITEMS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_vld_i,
   output logic              req_rdy_o,
   input  logic [6:0]        req_low_addr_i,
   input  logic [12:0]       req_byte_cnt_i,
   input  logic [10:0]       req_dw_cnt_i,
   input  logic [2:0]        req_status_i,
   input  logic [15:0]       req_rid_i,
   input  logic [7:0]        req_tag_i,
   input  logic [15:0]       req_cid_i,
   input  logic [2:0]        req_tc_i,
   input  logic [2:0]        req_attr_i,
   input  logic [DATA_W-1:0] rd_data_i,
   input  logic              rd_vld_i,
   output logic              rd_rdy_o,
   output logic [DATA_W-1:0] mfb_data_o,
   output logic              mfb_sof_o,
   output logic              mfb_eof_o,
   output logic              mfb_sof_pos_o,
   output logic [POS_W-1:0]  mfb_eof_pos_o,
   output logic              mfb_src_rdy_o,
   input  logic              mfb_dst_rdy_i
);

   localparam int DW    = MFB_ITEM_WIDTH;
   localparam int HDR_W = 3 * DW;
   localparam int NEW_W = DATA_W - HDR_W;

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_TAIL} state_t;

   state_t             state_q, state_d;
   logic [10:0]        n_q, n_d;
   logic [10:0]        rem_q, rem_d;
   logic [HDR_W-1:0]   desc_q, desc_d;
   logic [HDR_W-1:0]   carry_q, carry_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               sof_q, sof_d;
   logic               eof_q, eof_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic               src_q, src_d;

   logic               adv;
   logic               emit;
   logic               last;
   logic [DATA_W-1:0]  word;
   logic [POS_W-1:0]   eof_pos;

   assign adv     = !src_q || mfb_dst_rdy_i;
   assign eof_pos = POS_W'(n_q + 11'd2);

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      rem_d     = rem_q;
      desc_d    = desc_q;
      carry_d   = carry_q;
      data_d    = data_q;
      sof_d     = sof_q;
      eof_d     = eof_q;
      pos_d     = pos_q;
      src_d     = src_q;
      req_rdy_o = 1'b0;
      rd_rdy_o  = 1'b0;
      emit      = 1'b0;
      last      = 1'b0;
      word      = '0;

      case (state_q)
         S_IDLE: begin
            req_rdy_o = 1'b1;
            if (adv) src_d = 1'b0;
            if (req_vld_i) begin
               desc_d = {1'b0, req_attr_i, req_tc_i, 1'b0, req_cid_i, req_tag_i,
                         req_rid_i, 2'b00, req_status_i, req_dw_cnt_i,
                         3'b000, req_byte_cnt_i, 6'b0, 2'b00, 1'b0, req_low_addr_i};
               n_d     = req_dw_cnt_i;
               rem_d   = req_dw_cnt_i;
               state_d = S_HDR;
            end
         end
         S_HDR, S_BODY: begin
            rd_rdy_o = adv && rem_q != 11'd0;
            if (adv) begin
               // a zero-length completion frames the descriptor without waiting on data
               if (rem_q == 11'd0 || rd_vld_i) begin
                  emit    = 1'b1;
                  word    = {rd_data_i[NEW_W-1:0], (state_q == S_HDR) ? desc_q : carry_q};
                  last    = rem_q <= 11'd5;
                  carry_d = rd_data_i[DATA_W-1:NEW_W];
                  rem_d   = (rem_q > 11'd8) ? rem_q - 11'd8 : 11'd0;
                  if (last)               state_d = S_IDLE;
                  else if (rem_q <= 11'd8) state_d = S_TAIL;
                  else                    state_d = S_BODY;
               end else begin
                  src_d = 1'b0;
               end
            end
         end
         S_TAIL: begin
            if (adv) begin
               emit    = 1'b1;
               last    = 1'b1;
               word    = {{NEW_W{1'b0}}, carry_q};
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (emit) begin
         for (int i = 0; i < ITEMS; i++)
            if (last && POS_W'(i) > eof_pos) word[i*DW +: DW] = '0;
         data_d = word;
         sof_d  = (state_q == S_HDR);
         eof_d  = last;
         pos_d  = last ? eof_pos : '0;
         src_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         rem_q   <= '0;
         desc_q  <= '0;
         carry_q <= '0;
         data_q  <= '0;
         sof_q   <= 1'b0;
         eof_q   <= 1'b0;
         pos_q   <= '0;
         src_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         rem_q   <= rem_d;
         desc_q  <= desc_d;
         carry_q <= carry_d;
         data_q  <= data_d;
         sof_q   <= sof_d;
         eof_q   <= eof_d;
         pos_q   <= pos_d;
         src_q   <= src_d;
      end
   end

   assign mfb_data_o    = data_q;
   assign mfb_sof_o     = sof_q;
   assign mfb_eof_o     = eof_q;
   assign mfb_sof_pos_o = 1'b0;
   assign mfb_eof_pos_o = pos_q;
   assign mfb_src_rdy_o = src_q;

endmodule

// File: tb/tb_pcie_cc_cpl_framer.sv
// Bench for pcie_cc_cpl_framer: random requests, payload and backpressure against a
// DW-stream reference model (descriptor ++ payload, chopped into 8-DW words).
module tb_pcie_cc_cpl_framer;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic         req_vld, req_rdy;
   logic [6:0]   req_low_addr;
   logic [12:0]  req_byte_cnt;
   logic [10:0]  req_dw_cnt;
   logic [2:0]   req_status, req_tc, req_attr;
   logic [15:0]  req_rid, req_cid;
   logic [7:0]   req_tag;
   logic [255:0] rd_data;
   logic         rd_vld, rd_rdy;
   logic [255:0] mfb_data;
   logic         mfb_sof, mfb_eof, mfb_sof_pos, mfb_src_rdy, mfb_dst_rdy;
   logic [2:0]   mfb_eof_pos;

   pcie_cc_cpl_framer dut (
      .clk(clk), .rst_n(rst_n),
      .req_vld_i(req_vld), .req_rdy_o(req_rdy),
      .req_low_addr_i(req_low_addr), .req_byte_cnt_i(req_byte_cnt), .req_dw_cnt_i(req_dw_cnt),
      .req_status_i(req_status), .req_rid_i(req_rid), .req_tag_i(req_tag), .req_cid_i(req_cid),
      .req_tc_i(req_tc), .req_attr_i(req_attr),
      .rd_data_i(rd_data), .rd_vld_i(rd_vld), .rd_rdy_o(rd_rdy),
      .mfb_data_o(mfb_data), .mfb_sof_o(mfb_sof), .mfb_eof_o(mfb_eof),
      .mfb_sof_pos_o(mfb_sof_pos), .mfb_eof_pos_o(mfb_eof_pos),
      .mfb_src_rdy_o(mfb_src_rdy), .mfb_dst_rdy_i(mfb_dst_rdy)
   );

   typedef struct {
      int          n;
      logic [2:0]  status, tc, attr;
      logic [7:0]  tag;
      logic [6:0]  low;
      logic [12:0] bc;
      logic [15:0] rid, cid;
   } req_t;

   typedef struct packed {
      logic [255:0] data;
      logic         sof;
      logic         eof;
      logic [2:0]   pos;
   } word_t;

   req_t         req_q[$];
   logic [255:0] feed_q[$];
   word_t        exp_q[$];
   word_t        got_q[$];

   int checks = 0, errors = 0;
   int cyc, hs_cyc, src_cyc, stall_viol;
   int dst_pct, vld_pct;
   bit rd_rdy_seen;
   bit prev_stall;
   logic [261:0] prev_out;

   function automatic req_t rand_req(input int n);
      req_t r;
      r.n = n;
      r.status = 3'($urandom); r.tc = 3'($urandom); r.attr = 3'($urandom);
      r.tag = 8'($urandom); r.low = 7'($urandom); r.bc = 13'($urandom);
      r.rid = 16'($urandom); r.cid = 16'($urandom);
      return r;
   endfunction

   function automatic word_t got_at(input int i);
      word_t w;
      w = '0;
      if (i < got_q.size()) w = got_q[i];
      return w;
   endfunction

   // Reference: the frame is the DW list {desc0, desc1, desc2, payload...}, cut into 8-DW words.
   task automatic enqueue(input req_t r, input bit seq);
      logic [31:0]  pay[$];
      logic [31:0]  dws[$];
      logic [255:0] fw;
      word_t        w;
      int           len, nw;
      for (int i = 0; i < r.n; i++) pay.push_back(seq ? 32'(i) : $urandom);
      for (int k = 0; k < (r.n + 7) / 8; k++) begin
         for (int j = 0; j < 8; j++)
            fw[j*32 +: 32] = (k*8 + j < r.n) ? pay[k*8 + j] : $urandom;
         feed_q.push_back(fw);
      end
      dws.push_back((32'(r.bc) << 16) + 32'(r.low));
      dws.push_back((32'(r.rid) << 16) + (32'(r.status) << 11) + 32'(r.n));
      dws.push_back((32'(r.attr) << 28) + (32'(r.tc) << 25) + (32'(r.cid) << 8) + 32'(r.tag));
      foreach (pay[i]) dws.push_back(pay[i]);
      len = dws.size();
      nw  = (len + 7) / 8;
      for (int k = 0; k < nw; k++) begin
         w = '0;
         for (int j = 0; j < 8; j++)
            if (k*8 + j < len) w.data[j*32 +: 32] = dws[k*8 + j];
         w.sof = (k == 0);
         w.eof = (k == nw - 1);
         w.pos = w.eof ? 3'((len - 1) % 8) : 3'd0;
         exp_q.push_back(w);
      end
      req_q.push_back(r);
   endtask

   task automatic drive();
      mfb_dst_rdy = $urandom_range(99) < dst_pct;
      rd_vld      = feed_q.size() > 0 && $urandom_range(99) < vld_pct;
      rd_data     = feed_q.size() > 0 ? feed_q[0] : $urandom;
      req_vld     = req_q.size() > 0;
      if (req_q.size() > 0) begin
         req_low_addr = req_q[0].low; req_byte_cnt = req_q[0].bc; req_dw_cnt = 11'(req_q[0].n);
         req_status = req_q[0].status; req_rid = req_q[0].rid; req_tag = req_q[0].tag;
         req_cid = req_q[0].cid; req_tc = req_q[0].tc; req_attr = req_q[0].attr;
      end
   endtask

   task automatic step();
      word_t w;
      @(negedge clk);
      cyc++;
      if (mfb_src_rdy && src_cyc < 0) src_cyc = cyc;
      if (prev_stall && prev_out !== {mfb_data, mfb_sof, mfb_eof, mfb_eof_pos, mfb_src_rdy})
         stall_viol++;
      prev_stall = mfb_src_rdy && !mfb_dst_rdy;
      prev_out   = {mfb_data, mfb_sof, mfb_eof, mfb_eof_pos, mfb_src_rdy};
      if (mfb_src_rdy && mfb_dst_rdy) begin
         w.data = mfb_data; w.sof = mfb_sof; w.eof = mfb_eof; w.pos = mfb_eof_pos;
         got_q.push_back(w);
      end
      if (rd_rdy) rd_rdy_seen = 1'b1;
      if (rd_vld && rd_rdy) void'(feed_q.pop_front());
      if (req_vld && req_rdy) begin
         void'(req_q.pop_front());
         if (hs_cyc < 0) hs_cyc = cyc;
      end
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic run(input int budget, output bit ok);
      int c = 0;
      while ((got_q.size() < exp_q.size() || req_q.size() != 0) && c < budget) begin
         step();
         c++;
      end
      ok = c < budget;
      repeat (4) step();
   endtask

   task automatic clear(input int dp, input int vp);
      req_q.delete(); feed_q.delete(); exp_q.delete(); got_q.delete();
      cyc = 0; hs_cyc = -1; src_cyc = -1; stall_viol = 0;
      rd_rdy_seen = 1'b0; prev_stall = 1'b0;
      dst_pct = dp; vld_pct = vp;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #10;
      checks++;
      if ({mfb_src_rdy, mfb_sof, mfb_eof, mfb_eof_pos, mfb_sof_pos, mfb_data, rd_rdy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: src=%b sof=%b eof=%b pos=%0d rd_rdy=%b data=%h, required all 0",
                  mfb_src_rdy, mfb_sof, mfb_eof, mfb_eof_pos, rd_rdy, mfb_data);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      #1;
      checks++;
      if (req_rdy !== 1'b1) begin
         errors++; $display("FAIL reset_req_rdy: got %b required 1", req_rdy);
      end
   endtask

   task automatic test_no_payload();
      bit ok; req_t r;
      clear(100, 100);
      r = rand_req(0); r.status = 3'b001; r.tag = 8'h5A;
      enqueue(r, 1'b0); drive(); run(100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL nopay_timeout: got %0d words required %0d", got_q.size(), exp_q.size()); end
      checks++;
      if (got_q.size() != 1) begin errors++; $display("FAIL nopay_count: got %0d required 1", got_q.size()); end
      foreach (exp_q[i]) begin
         checks++;
         if (got_at(i) !== exp_q[i]) begin errors++; $display("FAIL nopay_word%0d: got %h required %h", i, got_at(i), exp_q[i]); end
      end
      checks++;
      if (got_at(0).data[71:64] !== 8'h5A || got_at(0).pos !== 3'd2 || !got_at(0).sof || !got_at(0).eof) begin
         errors++; $display("FAIL nopay_fields: tag=%h pos=%0d sof=%b eof=%b required 5a 2 1 1",
                            got_at(0).data[71:64], got_at(0).pos, got_at(0).sof, got_at(0).eof);
      end
      checks++;
      if (rd_rdy_seen) begin errors++; $display("FAIL nopay_rd_rdy: got rd_rdy high, required never"); end
   endtask

   task automatic test_single_word();
      bit ok;
      clear(100, 100);
      enqueue(rand_req(5), 1'b1); drive(); run(100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_timeout: got %0d words required %0d", got_q.size(), exp_q.size()); end
      checks++;
      if (got_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d required 1", got_q.size()); end
      foreach (exp_q[i]) begin
         checks++;
         if (got_at(i) !== exp_q[i]) begin errors++; $display("FAIL single_word%0d: got %h required %h", i, got_at(i), exp_q[i]); end
      end
      checks++;
      if (src_cyc - hs_cyc != 2) begin errors++; $display("FAIL single_latency: got %0d edges required 2", src_cyc - hs_cyc); end
   endtask

   task automatic test_tail();
      bit ok;
      clear(100, 100);
      enqueue(rand_req(8), 1'b1); drive(); run(100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL tail_timeout: got %0d words required %0d", got_q.size(), exp_q.size()); end
      checks++;
      if (got_q.size() != 2) begin errors++; $display("FAIL tail_count: got %0d required 2", got_q.size()); end
      foreach (exp_q[i]) begin
         checks++;
         if (got_at(i) !== exp_q[i]) begin errors++; $display("FAIL tail_word%0d: got %h required %h", i, got_at(i), exp_q[i]); end
      end
      checks++;
      if (got_at(1).pos !== 3'd2 || got_at(1).data[255:96] !== '0) begin
         errors++; $display("FAIL tail_last: pos=%0d upper=%h required 2 and 0", got_at(1).pos, got_at(1).data[255:96]);
      end
   endtask

   task automatic test_long_backpressure();
      bit ok;
      clear(50, 50);
      enqueue(rand_req(1024), 1'b0); drive(); run(8000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL long_timeout: got %0d words required %0d", got_q.size(), exp_q.size()); end
      checks++;
      if (got_q.size() != 129) begin errors++; $display("FAIL long_count: got %0d required 129", got_q.size()); end
      foreach (exp_q[i]) begin
         checks++;
         if (got_at(i) !== exp_q[i]) begin errors++; $display("FAIL long_word%0d: got %h required %h", i, got_at(i), exp_q[i]); end
      end
      checks++;
      if (stall_viol != 0) begin errors++; $display("FAIL long_stall: got %0d changes while stalled required 0", stall_viol); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      clear(100, 100);
      enqueue(rand_req(1), 1'b0); enqueue(rand_req(6), 1'b0); drive(); run(100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_timeout: got %0d words required %0d", got_q.size(), exp_q.size()); end
      checks++;
      if (got_q.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d required 3", got_q.size()); end
      foreach (exp_q[i]) begin
         checks++;
         if (got_at(i) !== exp_q[i]) begin errors++; $display("FAIL b2b_word%0d: got %h required %h", i, got_at(i), exp_q[i]); end
      end
      checks++;
      if (got_at(0).pos !== 3'd3 || got_at(2).pos !== 3'd0 || !got_at(2).eof) begin
         errors++; $display("FAIL b2b_pos: got %0d/%0d required 3/0", got_at(0).pos, got_at(2).pos);
      end
   endtask

   task automatic test_random();
      bit ok;
      clear(70, 70);
      for (int k = 0; k < 10; k++) enqueue(rand_req(int'($urandom_range(40))), 1'b0);
      drive(); run(4000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rand_timeout: got %0d words required %0d", got_q.size(), exp_q.size()); end
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d required %0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         checks++;
         if (got_at(i) !== exp_q[i]) begin errors++; $display("FAIL rand_word%0d: got %h required %h", i, got_at(i), exp_q[i]); end
      end
      checks++;
      if (stall_viol != 0) begin errors++; $display("FAIL rand_stall: got %0d changes while stalled required 0", stall_viol); end
   endtask

   task automatic test_reset_mid_frame();
      bit ok; int c; req_t r;
      clear(100, 100);
      enqueue(rand_req(64), 1'b0); drive();
      c = 0;
      while (got_q.size() < 2 && c < 50) begin step(); c++; end
      checks++;
      if (got_q.size() < 2 || !mfb_src_rdy) begin
         errors++; $display("FAIL rstmid_reach: got %0d words src=%b required 2 and 1", got_q.size(), mfb_src_rdy);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({mfb_src_rdy, mfb_sof, mfb_eof, mfb_eof_pos, mfb_data, rd_rdy} !== '0) begin
         errors++; $display("FAIL rstmid_outputs: src=%b sof=%b eof=%b pos=%0d rd_rdy=%b data=%h required all 0",
                            mfb_src_rdy, mfb_sof, mfb_eof, mfb_eof_pos, rd_rdy, mfb_data);
      end
      clear(100, 100);
      drive();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      r = rand_req(2);
      enqueue(r, 1'b0); drive(); run(100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rstmid_timeout: got %0d words required %0d", got_q.size(), exp_q.size()); end
      checks++;
      if (got_q.size() != 1) begin errors++; $display("FAIL rstmid_count: got %0d required 1", got_q.size()); end
      foreach (exp_q[i]) begin
         checks++;
         if (got_at(i) !== exp_q[i]) begin errors++; $display("FAIL rstmid_word%0d: got %h required %h", i, got_at(i), exp_q[i]); end
      end
      checks++;
      if (got_at(0).pos !== 3'd4) begin errors++; $display("FAIL rstmid_pos: got %0d required 4", got_at(0).pos); end
   endtask

   initial begin
      req_vld = 1'b0; req_low_addr = '0; req_byte_cnt = '0; req_dw_cnt = '0;
      req_status = '0; req_rid = '0; req_tag = '0; req_cid = '0; req_tc = '0; req_attr = '0;
      rd_data = '0; rd_vld = 1'b0; mfb_dst_rdy = 1'b1;
      test_reset();
      test_no_payload();
      test_single_word();
      test_tail();
      test_long_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
